sub8_pipe: RTL and testbench

- Two-stage pipelined 8-bit subtractor with borrow-in/borrow-out and ALU status flags; the subtract counterpart of the team's 8-bit carry-lookahead adder.
- Splits the operand into low and high nibbles. The borrow crosses the nibble boundary through a pipeline register.
- Sits between the operand-select logic and the ALU result mux. Uses valid/ready handshakes on both sides, so the datapath can stall without losing operations.

---
 rtl/sub8_pipe_pkg.sv | 15 +
 rtl/sub_n_bit.sv | 46 ++++
 rtl/sub8_pipe.sv | 112 +++++++++++
 tb/tb_sub8_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sub8_pipe_pkg.sv
// Shared ALU definitions used by the subtract path (and the adder path).
//   ALU_W        : ALU data width
//   alu_flags_t  : status flags produced alongside an ALU result
package sub8_pipe_pkg;

  localparam int ALU_W = 8;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
    logic borrow;
  } alu_flags_t;

endpackage

// File: rtl/sub_n_bit.sv
// Combinational N-bit lookahead-borrow subtractor: diff = in1 - in2 - bin.
//   in1, in2 : N-bit operands
//   bin      : borrow in
//   diff     : N-bit difference
//   bout     : borrow out of the MSB
module sub_n_bit #(
  parameter int N = 4
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout
);

  // A bit generates a borrow when it is 0 - 1, and passes an incoming
  // borrow through when both operand bits are equal.
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   b;

  assign g = ~in1 & in2;
  assign p = ~(in1 ^ in2);

  // Each borrow is an independent sum of products over g/p/bin, so no
  // borrow depends on the previously computed one.
  always_comb begin
    logic bi;
    logic pp;
    b    = '0;
    b[0] = bin;
    for (int i = 0; i < N; i++) begin
      bi = 1'b0;
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        bi = bi | (pp & g[j]);
        pp = pp & p[j];
      end
      b[i+1] = bi | (pp & bin);
    end
  end

  assign diff = in1 ^ in2 ^ b[N-1:0];
  assign bout = b[N];

endmodule

// File: rtl/sub8_pipe.sv
// Two-stage pipelined subtractor with borrow in/out and ALU flags.
// Stage 1 subtracts the low half and carries the mid borrow forward;
// stage 2 subtracts the high half and registers diff and flags.
//   clk, rst_n         : clock, async active-low reset
//   in_valid/in_ready  : operand handshake (in1, in2, bin)
//   out_valid/out_ready: result handshake (diff, bout, zero, neg, ovf)
// WIDTH must be even and >= 2.
module sub8_pipe
  import sub8_pipe_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int H = WIDTH / 2;

  // Stage 1 state. The operand MSBs needed for ovf are the top bits of
  // s1_ahi / s1_bhi.
  logic         s1_valid;
  logic [H-1:0] s1_dlo;
  logic         s1_bmid;
  logic [H-1:0] s1_ahi;
  logic [H-1:0] s1_bhi;

  alu_flags_t   flags_q;

  logic         s2_free, s1_adv, accept;
  logic [H-1:0] lo_diff, hi_diff;
  logic         lo_bout, hi_bout;
  logic         ovf_n;

  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s1_adv;
  assign accept   = in_valid && in_ready;

  sub_n_bit #(.N(H)) u_lo (
    .in1  (in1[H-1:0]),
    .in2  (in2[H-1:0]),
    .bin  (bin),
    .diff (lo_diff),
    .bout (lo_bout)
  );

  sub_n_bit #(.N(H)) u_hi (
    .in1  (s1_ahi),
    .in2  (s1_bhi),
    .bin  (s1_bmid),
    .diff (hi_diff),
    .bout (hi_bout)
  );

  // Signed overflow: operands of differing sign and a result whose sign
  // differs from the minuend.
  assign ovf_n = (s1_ahi[H-1] != s1_bhi[H-1]) && (hi_diff[H-1] != s1_ahi[H-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_dlo   <= '0;
      s1_bmid  <= 1'b0;
      s1_ahi   <= '0;
      s1_bhi   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_dlo   <= lo_diff;
      s1_bmid  <= lo_bout;
      s1_ahi   <= in1[WIDTH-1:H];
      s1_bhi   <= in2[WIDTH-1:H];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      diff      <= '0;
      flags_q   <= '0;
    end else if (s1_adv) begin
      out_valid      <= 1'b1;
      diff           <= {hi_diff, s1_dlo};
      flags_q.zero   <= ~|{hi_diff, s1_dlo};
      flags_q.neg    <= hi_diff[H-1];
      flags_q.ovf    <= ovf_n;
      flags_q.borrow <= hi_bout;
    end else if (out_ready) begin
      // result consumed with nothing behind it; data is left as is
      out_valid <= 1'b0;
    end
  end

  assign bout = flags_q.borrow;
  assign zero = flags_q.zero;
  assign neg  = flags_q.neg;
  assign ovf  = flags_q.ovf;

endmodule

// File: tb/tb_sub8_pipe.sv
// Self-checking bench for sub8_pipe: directed cases, streaming,
// backpressure, mid-operation reset and random traffic against an
// arithmetic reference model with a capacity-2 pipe occupancy model.
module tb_sub8_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] in1, in2;
  logic       bin;
  logic       out_valid, out_ready;
  logic [7:0] diff;
  logic       bout, zero, neg, ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bi;
  } op_t;

  typedef struct {
    logic [7:0] d;
    logic [3:0] fl;   // {bout, zero, neg, ovf}
    int         age;  // clock edges since accept, saturating at 2
  } exp_t;

  op_t  pend[$];
  exp_t mq[$];
  bit   offer = 1'b1;

  sub8_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(op_t o);
    exp_t e;
    int   d;
    d     = int'(o.a) - int'(o.b) - int'(o.bi);
    e.d   = d[7:0];
    e.fl  = {d < 0, e.d == 8'h00, e.d[7], (o.a[7] != o.b[7]) && (e.d[7] != o.a[7])};
    e.age = 0;
    return e;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_op(logic [7:0] a, logic [7:0] b, logic bi);
    op_t o;
    o.a = a; o.b = b; o.bi = bi;
    pend.push_back(o);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle();
    bit   exp_rdy, exp_ov, acc, oxf;
    op_t  o;
    exp_t e;
    in_valid = offer && (pend.size() > 0);
    if (pend.size() > 0) begin
      in1 = pend[0].a; in2 = pend[0].b; bin = pend[0].bi;
    end else begin
      in1 = 8'($urandom); in2 = 8'($urandom); bin = 1'($urandom);
    end
    #1;
    exp_rdy = (mq.size() < 2) || out_ready;
    exp_ov  = (mq.size() > 0) && (mq[0].age >= 2);
    chk("in_ready", {7'd0, in_ready}, {7'd0, exp_rdy});
    chk("out_valid", {7'd0, out_valid}, {7'd0, exp_ov});
    if (exp_ov) begin
      chk("diff", diff, mq[0].d);
      chk("flags", {4'd0, bout, zero, neg, ovf}, {4'd0, mq[0].fl});
    end
    acc = in_valid && exp_rdy;
    oxf = exp_ov && out_ready;
    @(posedge clk);
    if (oxf) void'(mq.pop_front());
    foreach (mq[i]) if (mq[i].age < 2) mq[i].age++;
    if (acc) begin
      o = pend.pop_front();
      e = model(o);
      e.age = 1;
      mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic run_drain(int maxc);
    int n = 0;
    while ((pend.size() > 0 || mq.size() > 0) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain", {7'd0, (pend.size() == 0 && mq.size() == 0)}, 8'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0; bin = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_diff", diff, 8'h00);
    chk("rst_flags", {4'd0, bout, zero, neg, ovf}, 8'd0);
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // basic latency: 0x50 - 0x20, result exactly 2 edges after accept
    push_op(8'h50, 8'h20, 1'b0);
    cycle();
    cycle();
    chk("lat_valid", {7'd0, out_valid}, 8'd1);
    chk("lat_diff", diff, 8'h30);
    run_drain(10);

    // borrow, overflow and zero cases
    push_op(8'h10, 8'h01, 1'b0);
    push_op(8'h00, 8'h01, 1'b0);
    push_op(8'h00, 8'h00, 1'b1);
    push_op(8'h80, 8'h01, 1'b0);
    push_op(8'h7F, 8'hFF, 1'b0);
    push_op(8'h05, 8'h05, 1'b0);
    run_drain(30);

    // streaming, 4 back-to-back
    push_op(8'h09, 8'h03, 1'b0);
    push_op(8'h20, 8'h21, 1'b0);
    push_op(8'hFF, 8'h0F, 1'b0);
    push_op(8'h40, 8'h40, 1'b0);
    run_drain(20);

    // backpressure: 6 stalled cycles with 3 ops offered
    out_ready = 1'b0;
    push_op(8'h33, 8'h11, 1'b0);
    push_op(8'h01, 8'h02, 1'b1);
    push_op(8'hC0, 8'h41, 1'b0);
    repeat (6) cycle();
    chk("bp_accepted", 8'(pend.size()), 8'd1);
    out_ready = 1'b1;
    run_drain(20);

    // reset with both stages full
    out_ready = 1'b0;
    push_op(8'hAA, 8'h55, 1'b0);
    push_op(8'h12, 8'h34, 1'b1);
    push_op(8'h77, 8'h66, 1'b0);
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("mrst_diff", diff, 8'h00);
    chk("mrst_in_ready", {7'd0, in_ready}, 8'd1);
    mq.delete();
    pend.delete();
    in_valid = 1'b1; in1 = 8'h99; in2 = 8'h11; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_hold", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cycle();
    push_op(8'h44, 8'h45, 1'b0);
    run_drain(10);

    // random traffic with random gaps and stalls
    for (int i = 0; i < 150; i++)
      push_op(8'($urandom), 8'($urandom), 1'($urandom));
    for (int n = 0; n < 2000 && (pend.size() > 0 || mq.size() > 0); n++) begin
      offer     = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    offer = 1'b1;
    out_ready = 1'b1;
    run_drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
